btc_job_master: RTL

BTC_JOB_MASTER -- requirements
Module: btc_job_master

---
 rtl/btc_job_master_pkg.sv | 29 ++
 rtl/btc_job_master_xfer.sv | 80 ++++++++
 rtl/btc_job_master.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/btc_job_master_pkg.sv
// Shared miner definitions: register map, header size and job FSM states.
// Used by the job master and by the miner register block.
package btc_job_master_pkg;

  localparam logic [7:0] REG_CTRL   = 8'h00;
  localparam logic [7:0] REG_HDR    = 8'h04;
  localparam logic [7:0] REG_STATUS = 8'h54;
  localparam logic [7:0] REG_NONCE  = 8'h58;

  localparam int         HDR_WORDS = 20;
  localparam logic [4:0] HDR_LAST  = 5'(HDR_WORDS - 1);

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CFG,
    ST_SNAP,
    ST_START,
    ST_GAP,
    ST_POLL,
    ST_NONCE,
    ST_RESULT
  } job_state_e;

  function automatic logic [7:0] hdr_addr(input logic [4:0] idx);
    return REG_HDR + {1'b0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/btc_job_master_xfer.sv
// Single Wishbone classic transaction engine with ack timeout.
// Drops cycle/strobe the cycle after ack, err or timeout is seen.
module wb_single_xfer
  import btc_job_master_pkg::*;
#(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [7:0]  req_addr,
  input  logic        req_we,
  input  logic [31:0] req_wdata,
  input  logic        ack_i,
  input  logic        err_i,
  output logic        cyc_o,
  output logic [7:0]  addr_o,
  output logic        we_o,
  output logic [31:0] wdata_o,
  output logic        done_o,
  output logic        err_o,
  output logic        tmo_o
);

  localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ACK_TIMEOUT - 1);

  logic          cyc_q, cyc_d;
  logic [7:0]    addr_q, addr_d;
  logic          we_q, we_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cyc_d   = cyc_q;
    addr_d  = addr_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    done_o  = cyc_q & ack_i & ~err_i;
    err_o   = cyc_q & err_i;
    tmo_o   = cyc_q & ~ack_i & ~err_i & (cnt_q == CNT_LAST);
    if (cyc_q) begin
      cnt_d = cnt_q + CW'(1);
      if (ack_i || err_i || tmo_o) begin
        cyc_d = 1'b0;
        we_d  = 1'b0;
        cnt_d = '0;
      end
    end else if (req) begin
      cyc_d   = 1'b1;
      addr_d  = req_addr;
      we_d    = req_we;
      wdata_d = req_wdata;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q   <= 1'b0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      cyc_q   <= cyc_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign cyc_o   = cyc_q;
  assign addr_o  = addr_q;
  assign we_o    = we_q;
  assign wdata_o = wdata_q;

endmodule

// File: rtl/btc_job_master.sv
// Streams a block header into the miner, starts it, polls for completion
// and returns the nonce or an error through a result handshake.
module btc_job_master
  import btc_job_master_pkg::*;
#(
  parameter int POLL_GAP    = 16,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        wbRst,
  input  logic        jobValid,
  output logic        jobReady,
  input  logic [31:0] jobWord,
  input  logic        cfgUseNonceIn,
  input  logic        cfgOneshot,
  output logic [7:0]  wbAddr,
  output logic [3:0]  wbSel,
  output logic        wbWe,
  output logic [31:0] wbWData,
  output logic        wbCycle,
  output logic        wbStrobe,
  output logic [2:0]  wbCti,
  output logic [1:0]  wbBte,
  input  logic [31:0] wbRData,
  input  logic        wbAck,
  input  logic        wbErr,
  output logic        resValid,
  output logic [31:0] resNonce,
  output logic        resFound,
  output logic        resError,
  input  logic        resReady,
  output logic        busy
);

  localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(POLL_GAP - 1);

  job_state_e    state_q, state_d;
  logic [4:0]    idx_q, idx_d;
  logic [31:0]   word_q, word_d;
  logic          have_q, have_d;
  logic          use_nonce_q, use_nonce_d;
  logic          oneshot_q, oneshot_d;
  logic          ref_q, ref_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          found_q, found_d;
  logic [31:0]   nonce_q, nonce_d;
  logic          error_q, error_d;

  logic        x_req, x_we, x_cyc, x_done, x_err, x_tmo;
  logic [7:0]  x_addr;
  logic [31:0] x_wdata;
  logic        job_rdy;

  wb_single_xfer #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) u_xfer (
    .clk      (clk),
    .rst      (wbRst),
    .req      (x_req),
    .req_addr (x_addr),
    .req_we   (x_we),
    .req_wdata(x_wdata),
    .ack_i    (wbAck),
    .err_i    (wbErr),
    .cyc_o    (x_cyc),
    .addr_o   (wbAddr),
    .we_o     (wbWe),
    .wdata_o  (wbWData),
    .done_o   (x_done),
    .err_o    (x_err),
    .tmo_o    (x_tmo)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    word_d      = word_q;
    have_d      = have_q;
    use_nonce_d = use_nonce_q;
    oneshot_d   = oneshot_q;
    ref_d       = ref_q;
    gap_d       = gap_q;
    found_d     = found_q;
    nonce_d     = nonce_q;
    error_d     = error_q;
    x_req       = 1'b0;
    x_addr      = REG_CTRL;
    x_we        = 1'b0;
    x_wdata     = '0;
    job_rdy     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        job_rdy = ~wbRst;
        if (jobValid && job_rdy) begin
          word_d      = jobWord;
          use_nonce_d = cfgUseNonceIn;
          oneshot_d   = cfgOneshot;
          have_d      = 1'b1;
          idx_d       = '0;
          error_d     = 1'b0;
          found_d     = 1'b0;
          nonce_d     = '0;
          state_d     = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // next word is only requested once the previous write has retired
        job_rdy = ~have_q & ~x_cyc & (idx_q != 5'd0);
        if (jobValid && job_rdy) begin
          word_d = jobWord;
          have_d = 1'b1;
        end
        x_req   = have_q & ~x_cyc;
        x_addr  = hdr_addr(idx_q);
        x_we    = 1'b1;
        x_wdata = word_q;
        if (x_done) begin
          have_d = 1'b0;
          if (idx_q == HDR_LAST) state_d = ST_CFG;
          else idx_d = idx_q + 5'd1;
        end
      end
      ST_CFG: begin
        x_req   = ~x_cyc;
        x_addr  = REG_CTRL;
        x_we    = 1'b1;
        x_wdata = {29'd0, oneshot_q, use_nonce_q, 1'b1};
        if (x_done) state_d = ST_SNAP;
      end
      ST_SNAP: begin
        x_req  = ~x_cyc;
        x_addr = REG_STATUS;
        if (x_done) begin
          ref_d   = wbRData[0];
          state_d = ST_START;
        end
      end
      ST_START: begin
        x_req  = ~x_cyc;
        x_addr = REG_STATUS;
        x_we   = 1'b1;
        if (x_done) begin
          gap_d   = '0;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        gap_d = gap_q + GW'(1);
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = ST_POLL;
        end
      end
      ST_POLL: begin
        x_req  = ~x_cyc;
        x_addr = REG_STATUS;
        if (x_done) begin
          gap_d = '0;
          if (wbRData[0] != ref_q) begin
            found_d = wbRData[1];
            state_d = ST_NONCE;
          end else begin
            state_d = ST_GAP;
          end
        end
      end
      ST_NONCE: begin
        x_req  = ~x_cyc;
        x_addr = REG_NONCE;
        if (x_done) begin
          nonce_d = wbRData;
          state_d = ST_RESULT;
        end
      end
      ST_RESULT: begin
        if (resReady) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (x_err || x_tmo) begin
      have_d  = 1'b0;
      error_d = 1'b1;
      found_d = 1'b0;
      nonce_d = '0;
      state_d = ST_RESULT;
    end
  end

  always_ff @(posedge clk) begin
    if (wbRst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      word_q      <= '0;
      have_q      <= 1'b0;
      use_nonce_q <= 1'b0;
      oneshot_q   <= 1'b0;
      ref_q       <= 1'b0;
      gap_q       <= '0;
      found_q     <= 1'b0;
      nonce_q     <= '0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      word_q      <= word_d;
      have_q      <= have_d;
      use_nonce_q <= use_nonce_d;
      oneshot_q   <= oneshot_d;
      ref_q       <= ref_d;
      gap_q       <= gap_d;
      found_q     <= found_d;
      nonce_q     <= nonce_d;
      error_q     <= error_d;
    end
  end

  assign jobReady = job_rdy;
  assign wbCycle  = x_cyc;
  assign wbStrobe = x_cyc;
  assign wbSel    = {4{x_cyc}};
  assign wbCti    = 3'b000;
  assign wbBte    = 2'b00;
  assign resValid = (state_q == ST_RESULT);
  assign resNonce = nonce_q;
  assign resFound = found_q;
  assign resError = error_q;
  assign busy     = (state_q != ST_IDLE);

endmodule
